// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int          StallBus    = 6;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;
    localparam int          IF_TO_ID_WD = 33;
    localparam int          BR_WD       = 33;
    localparam logic [31:0] ResetPC     = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        IF_STATE_BOOT = 2'd0,
        IF_STATE_RUN  = 2'd1,
        IF_STATE_HOLD = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the instruction SRAM read port,
// and latches a redirect that arrives while fetch is stalled.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic                   fetch_adel
);

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    if_state_e   state_q, state_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        hold;
    logic [31:0] next_pc;
    logic        unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign hold         = (stall[0] == Stop);
    assign unused_stall = ^stall[StallBus-1:1];

    // Live redirect beats a pending one; sequential fetch wraps naturally.
    assign next_pc = br_e         ? br_addr :
                     pend_valid_q ? pend_addr_q :
                                    pc_q + 32'd4;

    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        state_d      = state_q;
        unique case (state_q)
            IF_STATE_BOOT: begin
                if (!hold) begin
                    pc_d    = RESET_PC;
                    ce_d    = 1'b1;
                    state_d = IF_STATE_RUN;
                end
            end
            IF_STATE_RUN: begin
                if (!hold) begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                end else if (br_e) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = br_addr;
                    state_d      = IF_STATE_HOLD;
                end
            end
            IF_STATE_HOLD: begin
                if (!hold) begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                    state_d      = IF_STATE_RUN;
                end else if (br_e) begin
                    pend_addr_d = br_addr;
                end
            end
            default: begin
                state_d = IF_STATE_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC - 32'd4;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
            state_q      <= IF_STATE_BOOT;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            state_q      <= state_d;
        end
    end

    assign fetch_adel      = ce_q & (pc_q[1:0] != 2'b00);
    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_addr  = pc_q;
    assign inst_sram_en    = ce_q & ~fetch_adel;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table plus
// randomized traffic against a behavioural reference model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [StallBus-1:0]    stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic                   fetch_adel;

    int n_vec = 0;
    int n_bad = 0;

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
        .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .fetch_adel(fetch_adel)
    );

    always #5 clk = ~clk;

    // Reference model: what fetch should be doing, in plain terms.
    logic [31:0] m_pc;
    logic        m_ce;
    bit          m_booted;
    logic [31:0] m_pend[$];

    task automatic model_edge(input bit r, input bit s, input bit be,
                              input logic [31:0] ba);
        if (r) begin
            m_pc = RPC - 32'd4;
            m_ce = 1'b0;
            m_booted = 0;
            m_pend.delete();
        end else if (s) begin
            if (m_booted && be) begin
                m_pend.delete();
                m_pend.push_back(ba);
            end
        end else if (!m_booted) begin
            m_pc = RPC;
            m_ce = 1'b1;
            m_booted = 1;
        end else begin
            if (be) m_pc = ba;
            else if (m_pend.size() != 0) m_pc = m_pend[0];
            else m_pc = m_pc + 32'd4;
            m_pend.delete();
        end
    endtask

    task automatic check(input string nm, input logic ce, input logic [31:0] pc);
        logic adel, en;
        adel = ce && (pc % 4 != 0);
        en   = ce && !adel;
        n_vec++;
        if (if_to_id_bus !== {ce, pc} || inst_sram_addr !== pc ||
            fetch_adel !== adel || inst_sram_en !== en ||
            inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
            n_bad++;
            $display("FAIL %s: got bus=%h addr=%h adel=%b en=%b wen=%h wd=%h, want bus=%h adel=%b en=%b",
                     nm, if_to_id_bus, inst_sram_addr, fetch_adel, inst_sram_en,
                     inst_sram_wen, inst_sram_wdata, {ce, pc}, adel, en);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit be,
                        input logic [31:0] ba);
        rst    = r;
        stall  = {{(StallBus-1){1'b0}}, s};
        if (s && ($urandom_range(0, 1) == 1)) stall[StallBus-1:1] = '1;
        br_bus = {be, ba};
        @(posedge clk);
        #1;
        model_edge(r, s, be, ba);
    endtask

    typedef struct {
        bit          rst;
        bit          stl;
        bit          be;
        logic [31:0] ba;
        logic        ce;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit s, bit be, logic [31:0] ba,
                               logic ce, logic [31:0] pc);
        vec_t t;
        t.rst = r; t.stl = s; t.be = be; t.ba = ba; t.ce = ce; t.pc = pc;
        return t;
    endfunction

    initial begin
        // reset, boot, sequential fetch
        tbl.push_back(v(1, 0, 0, 0, 0, 32'hBFBF_FFFC));
        tbl.push_back(v(1, 0, 1, 32'h1234_5678, 0, 32'hBFBF_FFFC));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0000));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0004));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0008));
        // unstalled branch
        tbl.push_back(v(0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0100));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0104));
        // branch during stall is held then taken
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0200, 1, 32'hBFC0_0104));
        tbl.push_back(v(0, 1, 0, 0, 1, 32'hBFC0_0104));
        tbl.push_back(v(0, 1, 0, 0, 1, 32'hBFC0_0104));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0200));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0204));
        // live branch beats pending one
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0200, 1, 32'hBFC0_0204));
        tbl.push_back(v(0, 0, 1, 32'hBFC0_0300, 1, 32'hBFC0_0300));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0304));
        // misaligned target
        tbl.push_back(v(0, 0, 1, 32'hBFC0_0102, 1, 32'hBFC0_0102));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0106));
        tbl.push_back(v(0, 0, 1, 32'hBFC0_0400, 1, 32'hBFC0_0400));
        // newest pending wins, then reset drops it
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0500, 1, 32'hBFC0_0400));
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0600, 1, 32'hBFC0_0400));
        tbl.push_back(v(1, 1, 0, 0, 0, 32'hBFBF_FFFC));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0000));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0004));
        // newest pending wins on release
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0500, 1, 32'hBFC0_0004));
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0600, 1, 32'hBFC0_0004));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0600));
        // BOOT: stall holds, branch ignored
        tbl.push_back(v(1, 0, 0, 0, 0, 32'hBFBF_FFFC));
        tbl.push_back(v(0, 1, 1, 32'hBFC0_0700, 0, 32'hBFBF_FFFC));
        tbl.push_back(v(0, 0, 1, 32'hBFC0_0800, 1, 32'hBFC0_0000));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'hBFC0_0004));
        // wrap-around
        tbl.push_back(v(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'h0000_0000));
        tbl.push_back(v(0, 0, 0, 0, 1, 32'h0000_0004));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].stl, tbl[i].be, tbl[i].ba);
            check($sformatf("dir%0d", i), tbl[i].ce, tbl[i].pc);
        end

        for (int i = 0; i < 400; i++) begin
            bit r, s, be;
            logic [31:0] ba;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 9) < 3);
            be = ($urandom_range(0, 9) < 2);
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            step(r, s, be, ba);
            check($sformatf("rnd%0d", i), m_ce, m_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline; the producer end of the IF→ID interface. It owns the PC register and drives the synchronous instruction SRAM read port. It emits `if_to_id_bus` to the decode stage and consumes the decode stage's `br_bus` redirect. It also latches a redirect that arrives while fetch is stalled, so no branch is lost. Decode samples `if_to_id_bus` one cycle later, together with `inst_sram_rdata`.

## Interface
Parameters
- `RESET_PC`, 32'hBFC0_0000: address of the first fetched instruction after reset.

Ports
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Reset. Synchronous, active-high.
- `stall`  in  `StallBus`  Pipeline stall vector. Only `stall[0]` (PC hold) is used; `Stop`=1, `NoStop`=0.
- `br_bus`  in  `BR_WD` (33)  Redirect from decode: {br_e, br_addr[31:0]}.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  {ce, pc[31:0]}: valid flag and PC of the instruction being read.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_wen`  out  4  Byte write enables. Tied to 4'b0.
- `inst_sram_addr`  out  32  Fetch address.
- `inst_sram_wdata`  out  32  Tied to 32'b0.
- `fetch_adel`  out  1  Current PC is not word-aligned. Address-error flag for the exception logic.

## Operation
- Registers: `pc_reg`, `ce_reg`, `pend_valid`, `pend_addr`, and a 2-bit `state`.
- Outputs:
  - `if_to_id_bus` = {ce_reg, pc_reg}.
  - `inst_sram_addr` = pc_reg.
  - `inst_sram_en` = ce_reg & ~fetch_adel.
  - `fetch_adel` = ce_reg & (pc_reg[1:0] != 2'b00).
- Next-PC priority, applied only when `stall[0]==NoStop`:
  1. `br_e` gives `br_addr`.
  2. Otherwise `pend_valid` gives `pend_addr`.
  3. Otherwise `pc_reg + 32'd4`, modulo 2^32 (wraps from FFFF_FFFC to 0000_0000).
- States:
  - BOOT: entered on reset. `ce_reg`=0. On the first unstalled cycle, `pc_reg`←`RESET_PC`, `ce_reg`←1, go to RUN. A `br_e` seen in BOOT is ignored.
  - RUN: on an unstalled cycle, `pc_reg`←next-PC, `pend_valid`←0. On a stalled cycle, `pc_reg` holds. If `br_e`=1 while stalled, `pend_valid`←1, `pend_addr`←`br_addr`, go to HOLD.
  - HOLD: `pend_valid`=1 and `pc_reg` holds.
    - A further `br_e` while stalled overwrites `pend_addr`; the newest redirect wins.
    - On the first unstalled cycle, `pc_reg`←(`br_e` ? `br_addr` : `pend_addr`), `pend_valid`←0, go to RUN.
- Live `br_e` together with `pend_valid` on an unstalled cycle: the live `br_e` wins and the pending entry is discarded.
- Misaligned PC: `fetch_adel` asserts and the SRAM is not enabled. The PC still advances and redirects normally; exception handling redirects via `br_bus`.
- The `ce` bit continues to mark valid fetches. Decode inserts its own bubble on stall, and `if_fetch` does not zero the bus during a stall.

## Timing
- Reset values: `pc_reg`=RESET_PC−4 (32'hBFBF_FFFC), `ce_reg`=0, `pend_valid`=0, `pend_addr`=0, state=BOOT.
- Outputs during reset: `inst_sram_en`=0, `fetch_adel`=0, `if_to_id_bus`=33'h0_BFBF_FFFC.
- Reset asserted mid-operation returns all registers to reset values on the next edge. A pending redirect is dropped.
- Latency:
  - An unstalled `br_e` in cycle N makes `inst_sram_addr`=`br_addr` in N+1. Instruction data reaches decode in N+2.
  - The delay-slot instruction at pc+4 of the branch is already in flight and executes.
- Under stall, `inst_sram_addr` is stable. The SRAM re-reads the same word each cycle, which is harmless.
- `stall[0]` sampled at the edge has priority over every PC update except reset.

## Structure
- `lib/defines.vh` holds `StallBus`, `Stop`, `NoStop`, `IF_TO_ID_WD`, `BR_WD`, and a new `ResetPC` constant.
- Add `IF_STATE_*` state encodings: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
- Single module, no sub-modules. The next-PC mux is inline combinational logic.

## Test plan
- Reset release, no stall → cycle 1: ce=1, pc=BFC0_0000. Then BFC0_0004, BFC0_0008 on consecutive cycles. `inst_sram_en`=1.
- Unstalled `br_e`=1, `br_addr`=BFC0_0100 while pc=BFC0_0008 → next pc=BFC0_0100, then BFC0_0104.
- `stall[0]`=Stop for 3 cycles, with `br_e` pulsed on cycle 1 to BFC0_0200 → pc held for 3 cycles, `pend_valid`=1. The first unstalled cycle gives pc=BFC0_0200.
- Stalled, pending BFC0_0200, then live unstalled `br_e` to BFC0_0300 → pc=BFC0_0300 and the pending entry is discarded.
- Redirect to BFC0_0102 → `fetch_adel`=1 and `inst_sram_en`=0. Next pc=BFC0_0106 with `fetch_adel` still 1.
- `rst` asserted while in HOLD → next cycle: ce=0, pc=BFBF_FFFC, `pend_valid`=0. Restart fetches BFC0_0000.
